// File: rtl/soc_event_queue_pkg.sv
// Shared types and elaboration helpers for the SoC event queue.
// Sizing functions here are used by the top and the FIFO.
package soc_event_pkg;

    localparam int unsigned EVENT_ID_WIDTH_DEF = 32'd8;

    typedef logic [EVENT_ID_WIDTH_DEF-1:0] event_id_t;

    // True when nb sources can each get a distinct ID of w bits.
    function automatic bit id_width_ok(input int unsigned nb, input int unsigned w);
        if (nb < 32'd2) begin
            return 1'b0;
        end else if (w >= 32'd31) begin
            return 1'b1;
        end else begin
            return nb <= (32'd1 << w);
        end
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // Index width for n entries, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/soc_event_queue_if.sv
// Event-ID stream towards the fabric-controller event port.
// The queue is the master; the FC port is the slave.
interface soc_event_queue_if #(
    parameter int unsigned EVENT_ID_WIDTH = 8
);
    logic                      event_valid_o;
    logic [EVENT_ID_WIDTH-1:0] event_data_o;
    logic                      event_ready_i;

    modport master (
        output event_valid_o,
        output event_data_o,
        input  event_ready_i
    );

    modport slave (
        input  event_valid_o,
        input  event_data_o,
        output event_ready_i
    );
endinterface

// File: rtl/soc_event_queue_fifo.sv
// Circular-buffer FIFO for event IDs; no bypass in either direction.
// Depth need not be a power of two.
module soc_event_fifo
    import soc_event_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 32'd1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Full blocks a push even when a pop happens in the same cycle.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == '0);
        do_push_s = push & ~full_s;
        do_pop_s  = pop & ~empty_s;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/soc_event_queue.sv
// Collects per-source event pulses into pending bits, round-robin arbitrates
// one per cycle into a FIFO, and streams event IDs to the FC event port.
module soc_event_queue
    import soc_event_pkg::*;
#(
    parameter int unsigned NB_EVENTS      = 32,
    parameter int unsigned EVENT_ID_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NB_EVENTS-1:0] events_i,
    soc_event_queue_if.master    fc,
    output logic                 overflow_o
);

    localparam int unsigned PTR_W = idx_width(NB_EVENTS);

    if (!id_width_ok(NB_EVENTS, EVENT_ID_WIDTH)) begin : g_bad_nb_events
        $error("soc_event_queue: NB_EVENTS must be in [2, 2**EVENT_ID_WIDTH]");
    end
    if (FIFO_DEPTH < 32'd2) begin : g_bad_fifo_depth
        $error("soc_event_queue: FIFO_DEPTH must be at least 2");
    end

    logic [NB_EVENTS-1:0]      pend_r;
    logic [NB_EVENTS-1:0]      pend_nxt_s;
    logic [NB_EVENTS-1:0]      gnt_vec_s;
    logic [NB_EVENTS-1:0]      drop_s;
    logic [PTR_W-1:0]          ptr_r;
    logic [PTR_W-1:0]          gnt_idx_s;
    logic                      found_s;
    logic                      grant_s;
    logic                      overflow_r;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic                      pop_s;
    logic [EVENT_ID_WIDTH-1:0] push_id_s;
    logic [EVENT_ID_WIDTH-1:0] fifo_rdata_s;

    // Round-robin search starting at ptr_r, wrapping past NB_EVENTS-1.
    always_comb begin
        int unsigned idx_v;
        logic [PTR_W-1:0] idx_w;
        found_s   = 1'b0;
        gnt_idx_s = '0;
        idx_v     = 32'd0;
        idx_w     = '0;
        for (int unsigned k = 0; k < NB_EVENTS; k++) begin
            idx_v = 32'(ptr_r) + k;
            if (idx_v >= NB_EVENTS) begin
                idx_v = idx_v - NB_EVENTS;
            end else begin
                idx_v = idx_v;
            end
            idx_w = idx_v[PTR_W-1:0];
            if (!found_s && pend_r[idx_w]) begin
                found_s   = 1'b1;
                gnt_idx_s = idx_w;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // A new pulse on the granted source re-arms it instead of being dropped.
    always_comb begin
        grant_s   = found_s & ~fifo_full_s;
        gnt_vec_s = '0;
        if (grant_s) begin
            gnt_vec_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_vec_s = '0;
        end
        drop_s     = events_i & pend_r & ~gnt_vec_s;
        pend_nxt_s = (pend_r & ~gnt_vec_s) | events_i;
        push_id_s  = '0;
        push_id_s[PTR_W-1:0] = gnt_idx_s;
        pop_s      = ~fifo_empty_s & fc.event_ready_i;
    end

    // Pending bits, arbitration pointer and overflow pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_r     <= '0;
            ptr_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            pend_r     <= pend_nxt_s;
            overflow_r <= |drop_s;
            if (grant_s) begin
                ptr_r <= (gnt_idx_s == PTR_W'(NB_EVENTS - 32'd1)) ? '0 : gnt_idx_s + PTR_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    soc_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_ID_WIDTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (grant_s),
        .pop   (pop_s),
        .wdata (push_id_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign fc.event_valid_o = ~fifo_empty_s;
    assign fc.event_data_o  = fifo_rdata_s;
    assign overflow_o       = overflow_r;

endmodule
